// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer.
//   state_t        : sequencer FSM states
//   SLOT_QUARTERS  : quarters per bus slot
//   BYTES_PER_WORD : bytes per write transaction (address + two data bytes)
//   default_word() : codec power-up control word table
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int SLOT_QUARTERS   = 4;
  localparam int BYTES_PER_WORD  = 3;
  localparam int N_DEFAULT_WORDS = 9;

  // Codec register writes in the order the codec needs them: reset,
  // power-up, path routing, format, sample rate, then activate.
  function automatic logic [15:0] default_word(input logic [7:0] idx);
    logic [15:0] w;
    case (idx)
      8'd0:    w = 16'h1E00;
      8'd1:    w = 16'h0C00;
      8'd2:    w = 16'h0A00;
      8'd3:    w = 16'h0E53;
      8'd4:    w = 16'h0814;
      8'd5:    w = 16'h0579;
      8'd6:    w = 16'h0117;
      8'd7:    w = 16'h1000;
      8'd8:    w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cfg_rom.sv
// Configuration word table.
//   idx  : word index
//   word : control word at idx; 16'h0000 for idx >= N_WORDS
module cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int N_WORDS = 9
) (
  input  logic [7:0]  idx,
  output logic [15:0] word
);

  always_comb begin
    word = (int'(idx) < N_WORDS) ? default_word(idx) : 16'h0000;
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// I2C configuration sequencer: writes N_WORDS control words to one slave,
// one (address, data_hi, data_lo) write per word, retrying NACKed words.
//   clock, reset_n      : system clock, asynchronous active-low reset
//   start               : one-cycle pulse, restarts the table from word 0
//   scl_oe, sda_oe      : open-drain pulls (1 = drive low)
//   sda_i               : synchronised SDA pad level
//   busy, done, error   : run status; done/error hold until next start
//   err_index           : failing word index while error = 1
//   retry_total         : retries in the current run, saturating
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_DIV    = 64,
  parameter int         N_WORDS    = 9,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_index,
  output logic [7:0] retry_total
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [1:0] Q_LAST = 2'(SLOT_QUARTERS - 1);

  state_t      state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]  quarter;
  logic        qtick;
  logic        slot_end;
  logic        launch;
  logic        auto_pend;
  logic [23:0] shreg;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  idx;
  logic [7:0]  retry_cnt;
  logic        nack;
  logic        last_byte;
  logic        last_word;
  logic        retries_spent;
  logic [15:0] rom_word;

  cfg_rom #(.N_WORDS(N_WORDS)) u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  assign qtick         = (qcnt == QW'(CLK_DIV - 1));
  assign slot_end      = qtick && (quarter == Q_LAST);
  assign last_byte     = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign last_word     = (idx == 8'(N_WORDS - 1));
  assign retries_spent = (retry_cnt == 8'(MAX_RETRY));
  assign busy          = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign done          = (state == ST_DONE);
  assign error         = (state == ST_FAIL);
  // A start while busy is ignored; auto_pend fires the power-up run.
  assign launch        = !busy && (start || auto_pend);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (launch) state_nxt = ST_START;
      ST_START: if (slot_end) state_nxt = ST_BIT;
      ST_BIT:   if (slot_end && bit_cnt == 3'd7) state_nxt = ST_ACK;
      ST_ACK: begin
        // A NACK aborts the frame at once; the rest of the word is dropped.
        if (slot_end) state_nxt = (nack || last_byte) ? ST_STOP : ST_BIT;
      end
      ST_STOP:  if (slot_end) state_nxt = ST_GAP;
      ST_GAP: begin
        if (slot_end) begin
          if (nack)           state_nxt = retries_spent ? ST_FAIL : ST_START;
          else if (last_word) state_nxt = ST_DONE;
          else                state_nxt = ST_START;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend   <= AUTO_START;
      qcnt        <= '0;
      quarter     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      idx         <= '0;
      retry_cnt   <= '0;
      nack        <= 1'b0;
      err_index   <= '0;
      retry_total <= '0;
    end else begin
      auto_pend <= 1'b0;

      // Quarter timer runs only during a run; it wraps to q0 exactly at
      // each slot boundary, so every slot starts aligned.
      if (!busy) begin
        qcnt    <= '0;
        quarter <= '0;
      end else if (qtick) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      if (launch) begin
        idx         <= '0;
        retry_cnt   <= '0;
        retry_total <= '0;
        err_index   <= '0;
      end

      unique case (state)
        ST_START: begin
          if (slot_end) begin
            shreg    <= {DEV_ADDR, 1'b0, rom_word};
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        ST_BIT: begin
          if (slot_end) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_ACK: begin
          // Sample on the last cycle of q2, while SCL is still high.
          if (qtick && quarter == 2'd2) nack <= sda_i;
          if (slot_end && !nack && !last_byte) byte_cnt <= byte_cnt + 2'd1;
        end
        ST_GAP: begin
          if (slot_end) begin
            if (nack) begin
              if (retries_spent) begin
                err_index <= idx;
              end else begin
                retry_cnt <= retry_cnt + 8'd1;
                if (retry_total != 8'hFF) retry_total <= retry_total + 8'd1;
              end
            end else if (!last_word) begin
              idx       <= idx + 8'd1;
              retry_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pad pulls decoded from registered state; IDLE after reset releases both
  // lines while reset_n is still low.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      ST_START: begin
        scl_oe = (quarter == 2'd3);
        sda_oe = quarter[1];
      end
      ST_BIT: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        sda_oe = ~shreg[23];
      end
      ST_ACK: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
      end
      ST_STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = ~quarter[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: an I2C slave model decodes frames off the pad pulls,
// ACKs or NACKs per a directed policy, and a scoreboard queue holds the
// frames each run is expected to deliver.
module tb_i2c_cfg_seq;

  localparam int CLK_DIV   = 2;
  localparam int N_WORDS   = 9;
  localparam int MAX_RETRY = 3;
  localparam int WORD_CYC  = 120 * CLK_DIV;
  localparam int SLOT_CYC  = 4 * CLK_DIV;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       scl_oe, sda_oe, sda_i;
  logic       busy, done, error;
  logic [7:0] err_index, retry_total;

  logic       ns_start;
  logic       ns_scl_oe, ns_sda_oe, ns_sda_i;
  logic       ns_busy, ns_done, ns_error;
  logic [7:0] ns_err_index, ns_retry_total;

  logic       slave_pull;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Slave bookkeeping (written only by the slave process)
  int frames_ok   = 0;
  int aborted     = 0;
  int nacks_given = 0;

  // NACK policy (written only by the main process)
  int nack_byte      = 0;
  int nack_word_abs  = 0;
  int nack_limit_abs = 0;

  logic [23:0] exp_q[$];
  logic [15:0] tbl [N_WORDS] = '{16'h1E00, 16'h0C00, 16'h0A00, 16'h0E53,
                                 16'h0814, 16'h0579, 16'h0117, 16'h1000,
                                 16'h1201};

  assign sda_i    = ~(sda_oe | slave_pull);
  assign ns_sda_i = 1'b0;

  i2c_cfg_seq #(
    .CLK_DIV(CLK_DIV), .N_WORDS(N_WORDS), .DEV_ADDR(7'h1A),
    .MAX_RETRY(MAX_RETRY), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index), .retry_total(retry_total)
  );

  i2c_cfg_seq #(
    .CLK_DIV(CLK_DIV), .N_WORDS(N_WORDS), .DEV_ADDR(7'h1A),
    .MAX_RETRY(MAX_RETRY), .AUTO_START(1'b0)
  ) u_dut_ns (
    .clock(clock), .reset_n(reset_n), .start(ns_start),
    .scl_oe(ns_scl_oe), .sda_oe(ns_sda_oe), .sda_i(ns_sda_i),
    .busy(ns_busy), .done(ns_done), .error(ns_error),
    .err_index(ns_err_index), .retry_total(ns_retry_total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++) exp_q.push_back({8'h34, tbl[w]});
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_end(output int t_end);
    int k;
    k = 0;
    while (!(done || error) && k < 8000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 8000) check("run_timeout", 32'd0, 32'd1);
    t_end = cyc;
  endtask

  // Slave model and scoreboard monitor, sampling at the falling clock edge.
  initial begin
    logic        scl_p, sda_p, scl_n, sda_n;
    logic        in_frame, nacked, nack_it;
    logic [7:0]  cur;
    logic [23:0] frame, e;
    int          bits, nbytes;
    scl_p = 1'b1; sda_p = 1'b1; in_frame = 1'b0; nacked = 1'b0;
    cur = '0; frame = '0; bits = 0; nbytes = 0;
    slave_pull = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        slave_pull = 1'b0; in_frame = 1'b0; bits = 0; nbytes = 0;
        scl_p = 1'b1; sda_p = 1'b1;
      end else begin
        scl_n = ~scl_oe;
        sda_n = ~(sda_oe | slave_pull);
        if (scl_p && scl_n && sda_p && !sda_n) begin
          in_frame = 1'b1; nacked = 1'b0; bits = 0; nbytes = 0; frame = '0;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
          if (in_frame) begin
            if (nbytes == 3 && !nacked) begin
              frames_ok++;
              if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'd1, 32'd0);
              end else begin
                e = exp_q.pop_front();
                check("frame", 32'(frame), 32'(e));
              end
            end else begin
              aborted++;
            end
          end
          in_frame = 1'b0;
        end else if (in_frame && !scl_p && scl_n) begin
          if (bits < 8) begin
            cur = {cur[6:0], sda_n};
            bits++;
          end else begin
            bits = 0;
          end
        end else if (in_frame && scl_p && !scl_n) begin
          if (bits == 8) begin
            nack_it = (nack_byte == nbytes + 1) && (frames_ok == nack_word_abs)
                      && (nacks_given < nack_limit_abs);
            frame = {frame[15:0], cur};
            nbytes++;
            if (nack_it) begin
              nacked = 1'b1;
              nacks_given++;
            end else begin
              slave_pull = 1'b1;
            end
          end else begin
            slave_pull = 1'b0;
          end
        end
        scl_p = scl_n;
        sda_p = sda_n;
      end
    end
  end

  initial begin
    int t0, t1, ab0, dummy;
    reset_n = 1'b0; start = 1'b0; ns_start = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    check("rst_retry_total", 32'(retry_total), 32'd0);

    // Auto-start run, slave always ACKs
    push_words(N_WORDS);
    ab0 = aborted;
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    t0 = cyc;
    check("auto_busy", 32'(busy), 32'd1);
    wait_end(t1);
    check("auto_done_time", 32'(t1 - t0), 32'(N_WORDS * WORD_CYC));
    check("auto_done", 32'(done), 32'd1);
    check("auto_error", 32'(error), 32'd0);
    check("auto_retry_total", 32'(retry_total), 32'd0);
    check("auto_aborted", 32'(aborted - ab0), 32'd0);
    check("auto_queue_left", 32'(exp_q.size()), 32'd0);

    // AUTO_START=0 instance stays idle until its first start
    check("ns_idle_busy", 32'(ns_busy), 32'd0);
    check("ns_idle_scl", 32'(ns_scl_oe), 32'd0);
    check("ns_idle_sda", 32'(ns_sda_oe), 32'd0);
    @(negedge clock) ns_start = 1'b1;
    @(negedge clock) ns_start = 1'b0;
    check("ns_start_busy", 32'(ns_busy), 32'd1);
    repeat (4) @(negedge clock);
    check("ns_start_q2_sda", 32'(ns_sda_oe), 32'd1);
    check("ns_start_q2_scl", 32'(ns_scl_oe), 32'd0);

    // Word 3 NACKed once on byte 2: full resend, one retry
    nack_byte = 2; nack_word_abs = frames_ok + 3; nack_limit_abs = nacks_given + 1;
    push_words(N_WORDS);
    ab0 = aborted;
    pulse_start(t0);
    check("retry_start_done_cleared", 32'(done), 32'd0);
    wait_end(t1);
    check("retry_done_time", 32'(t1 - t0),
          32'(N_WORDS * WORD_CYC + (1 + 9 * 2 + 2) * SLOT_CYC));
    check("retry_done", 32'(done), 32'd1);
    check("retry_error", 32'(error), 32'd0);
    check("retry_retry_total", 32'(retry_total), 32'd1);
    check("retry_aborted", 32'(aborted - ab0), 32'd1);
    check("retry_queue_left", 32'(exp_q.size()), 32'd0);

    // Address byte NACKed forever on word 5: 4 attempts then FAIL
    nack_byte = 1; nack_word_abs = frames_ok + 5; nack_limit_abs = nacks_given + 1000;
    push_words(5);
    ab0 = aborted;
    pulse_start(t0);
    wait_end(t1);
    check("fail_time", 32'(t1 - t0),
          32'(5 * WORD_CYC + (MAX_RETRY + 1) * 12 * SLOT_CYC));
    check("fail_error", 32'(error), 32'd1);
    check("fail_err_index", 32'(err_index), 32'd5);
    check("fail_done", 32'(done), 32'd0);
    check("fail_busy", 32'(busy), 32'd0);
    check("fail_scl_oe", 32'(scl_oe), 32'd0);
    check("fail_sda_oe", 32'(sda_oe), 32'd0);
    check("fail_retry_total", 32'(retry_total), 32'(MAX_RETRY));
    check("fail_attempts", 32'(aborted - ab0), 32'(MAX_RETRY + 1));
    check("fail_queue_left", 32'(exp_q.size()), 32'd0);

    // Start after FAIL clears status; a start while busy changes nothing
    nack_byte = 0;
    push_words(N_WORDS);
    pulse_start(t0);
    check("restart_error_cleared", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_retry_total", 32'(retry_total), 32'd0);
    repeat (300) @(negedge clock);
    pulse_start(dummy);
    wait_end(t1);
    check("restart_done_time", 32'(t1 - t0), 32'(N_WORDS * WORD_CYC));
    check("restart_done", 32'(done), 32'd1);
    check("restart_queue_left", 32'(exp_q.size()), 32'd0);

    // Reset during word 2's address byte, after one retry on word 0
    nack_byte = 3; nack_word_abs = frames_ok; nack_limit_abs = nacks_given + 1;
    push_words(N_WORDS);
    pulse_start(t0);
    t1 = 0;
    while (frames_ok < nack_word_abs + 2 && t1 < 3000) begin
      @(negedge clock);
      t1++;
    end
    check("midrun_reached_word2", 32'(t1 < 3000), 32'd1);
    repeat (40) @(negedge clock);
    check("midrun_retry_total", 32'(retry_total), 32'd1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_scl_oe", 32'(scl_oe), 32'd0);
    check("midrst_sda_oe", 32'(sda_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_retry_total", 32'(retry_total), 32'd0);
    check("midrst_queue_left", 32'(exp_q.size()), 32'(N_WORDS - 2));
    exp_q.delete();
    push_words(N_WORDS);
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    t0 = cyc;
    check("rerun_busy", 32'(busy), 32'd1);
    wait_end(t1);
    check("rerun_done_time", 32'(t1 - t0), 32'(N_WORDS * WORD_CYC));
    check("rerun_done", 32'(done), 32'd1);
    check("rerun_queue_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
# i2c_cfg_seq

Parametrised I2C configuration sequencer for the audio codec path. Out of reset, or on a `start` pulse, it writes a table of N_WORDS 16-bit control words to one I2C slave, one write transaction per word (device address byte plus two data bytes). It retries NACKed words a bounded number of times and reports completion or failure with the failing word index. It sits between the top level's open-drain pad drivers and the codec, ahead of the FIR filter data path, which must hold off until `done`.

## Interface
- CLK_DIV, 64: `clock` cycles per quarter SCL period; SCL = f_clock/(4·CLK_DIV) (64 at 50 MHz ≈ 195 kHz); legal ≥ 2
- N_WORDS, 9: table length; legal 1..255
- DEV_ADDR, 7'h1A: 7-bit slave address; R/W bit is always 0 (write)
- MAX_RETRY, 3: retries per word after NACK before failure; 0 = no retry
- AUTO_START, 1: 1 = run the sequence once after reset release
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts the sequence from word 0
- scl_oe  out  1  1 = pull SCL low; 0 = release
- sda_oe  out  1  1 = pull SDA low; 0 = release
- sda_i  in  1  SDA pad level, already synchronised by the parent
- busy  out  1  sequence in progress
- done  out  1  all words ACKed; held until next start or reset
- error  out  1  a word exceeded MAX_RETRY; held until next start or reset
- err_index  out  8  index of the failing word; valid while `error` = 1
- retry_total  out  8  retries in the current run; saturates at 255

## Operation
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, error=0, err_index=0, retry_total=0. State goes to IDLE, or to START if AUTO_START=1, on the first clock after release.
- Quarter tick: a counter 0..CLK_DIV-1 produces `qtick`. A 2-bit quarter index q0..q3 advances on each `qtick`. One slot = 4 quarters.
- Slot waveforms; each quarter's value is driven from its first cycle:
  - START: SCL released q0–q2, low q3. SDA released q0–q1, low q2–q3.
  - BIT: SCL low q0, released q1–q2, low q3. SDA is set at q0 from the current bit (1 → release, 0 → pull) and held through q3.
  - ACK: same as BIT with SDA released. `sda_i` is sampled on the last cycle of q2; 0 = ACK.
  - STOP: SCL low q0, released q1–q3. SDA low q0–q1, released q2–q3.
  - GAP: both lines released for one slot.
- FSM states: IDLE, START, BIT, ACK, STOP, GAP, DONE, FAIL.
  - IDLE/DONE/FAIL → START on `start`. This clears done, error and retry_total and sets the word index to 0.
  - START → BIT. The shift register loads {DEV_ADDR, 1'b0, word[idx]}, 24 bits, MSB first.
  - BIT → ACK after 8 bits. ACK → BIT (next byte), or → STOP after byte 3 or on NACK.
  - On NACK the transaction is aborted immediately: STOP follows the failed ACK slot and the remaining bytes are not sent.
  - STOP → GAP. GAP then resolves to one of:
    - next word (idx+1), retry counter cleared → START
    - retry same word → START
    - all words ACKed → DONE
    - NACK with retries exhausted → FAIL with err_index=idx
- busy=1 in all states except IDLE, DONE and FAIL.
- `start` while busy is ignored.
- Table lookup is combinational from `cfg_rom`, indexed by the 8-bit word index.
- No clock stretching and no arbitration: SCL is never read back.

## Timing
- Slot = 4·CLK_DIV clocks. Successful word = START + 27 bit/ack slots + STOP + GAP = 30 slots = 120·CLK_DIV clocks.
- `start` seen at cycle t → scl_oe/sda_oe reflect START q0 at t+1 and busy=1 at t+1.
- Full success: done rises 120·CLK_DIV·N_WORDS (+ retry slots) cycles after START entry.
- NACK on byte k (1..3) costs 1 + 9k + 2 slots before the retry START.
- A reset_n assertion mid-transaction releases both lines within the asynchronous reset. The slave sees an aborted frame; the next run begins with a fresh START.

## Structure
- Package `i2c_cfg_pkg`: state enum, slot-length constant (4), byte count per word (3), default codec table constants (1E00, 0C00, 0A00, 0E53, 0814, 0579, 0117, 1000, 1201).
- Sub-module `cfg_rom`: parameter N_WORDS; input idx[7:0], output word[15:0]. It returns the package defaults; out-of-range indices return 16'h0000.

## Test plan
- Slave model always ACKs, CLK_DIV=2, defaults → 9 frames decoded as 34 1E 00 … 34 12 01; done=1 at START+2160 cycles; error=0; retry_total=0.
- Slave NACKs byte 2 of word 3 once → word 3 resent in full; done=1; retry_total=1; all 9 words received exactly once ACKed.
- Slave NACKs the address byte permanently on word 5, MAX_RETRY=3 → 4 attempts on word 5; error=1; err_index=5; done=0; busy=0; lines released.
- reset_n pulsed low during BIT slot of word 2 → scl_oe=sda_oe=0 immediately; all status outputs 0; AUTO_START rerun begins at word 0.
- `start` pulsed while busy → no effect on frame sequence; `start` after FAIL → error cleared, rerun from word 0.
- AUTO_START=0 → lines released and busy=0 until the first `start` pulse.
